game_flow_ctrl: RTL and testbench

GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

---
 rtl/game_flow_pkg.sv | 16 +
 rtl/game_flow_if.sv | 27 ++
 rtl/game_timer.sv | 31 +++
 rtl/game_flow_ctrl.sv | 124 ++++++++++++
 tb/tb_game_flow_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/game_flow_pkg.sv
// game_flow_pkg: shared state encoding and defaults
// for the game flow controller.
package game_flow_pkg;

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  localparam int unsigned START_CYCLES_DEF = 125_000_000;
  localparam int unsigned OVER_HOLD_DEF    = 250_000_000;
  localparam int unsigned CNT_W_DEF        = 30;

endpackage

// File: rtl/game_flow_if.sv
// game_flow_if: button/request inputs and phase
// outputs of the game flow controller.
interface game_flow_if;

  logic       start_i;
  logic       pause_i;
  logic       over_i;
  logic       ready_o;
  logic       play_o;
  logic       pause_o;
  logic       over_o;
  logic [1:0] state_o;
  logic       clear_o;

  modport master (
    output start_i, pause_i, over_i,
    input  ready_o, play_o, pause_o,
    input  over_o, state_o, clear_o
  );

  modport slave (
    input  start_i, pause_i, over_i,
    output ready_o, play_o, pause_o,
    output over_o, state_o, clear_o
  );

endinterface

// File: rtl/game_timer.sv
// game_timer: phase counter with sync clear and
// a terminal flag at LIMIT-1 (LIMIT=0: never).
module game_timer #(
  parameter int unsigned LIMIT = 10,
  parameter int unsigned CNT_W = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt;

  // clear wins over enable; count otherwise holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + CNT_W'(1);
  end

  assign tc = (LIMIT != 0) && (cnt == LAST);

endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: READY/PLAY/PAUSE/OVER sequencer.
// PAUSE exists only with GAME_FLOW_PAUSE_EN defined.
module game_flow_ctrl
  import game_flow_pkg::*;
#(
  parameter int unsigned START_CYCLES     = START_CYCLES_DEF,
  parameter int unsigned OVER_HOLD_CYCLES = OVER_HOLD_DEF,
  parameter int unsigned CNT_W            = CNT_W_DEF
) (
  input logic        clk,
  input logic        rst_n,
  game_flow_if.slave bus
);

  state_e state_q;
  state_e state_d;
  logic   start_q;
  logic   start_edge;
  logic   rdy_tc;
  logic   ovr_tc;
  logic   chg;

  // start history resets high so a held button is no edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      start_q <= 1'b1;
    else
      start_q <= bus.start_i;
  end

  assign start_edge = bus.start_i & ~start_q;

`ifdef GAME_FLOW_PAUSE_EN
  logic pause_q;
  logic pause_edge;

  // pause history, same reset rule as start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pause_q <= 1'b1;
    else
      pause_q <= bus.pause_i;
  end

  assign pause_edge = bus.pause_i & ~pause_q;
`endif

  // next-state selection; over_i outranks pause
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_READY:
        if (start_edge || rdy_tc)
          state_d = ST_PLAY;
      ST_PLAY:
        if (bus.over_i)
          state_d = ST_OVER;
`ifdef GAME_FLOW_PAUSE_EN
        else if (pause_edge)
          state_d = ST_PAUSE;
      ST_PAUSE:
        if (pause_edge)
          state_d = ST_PLAY;
`endif
      ST_OVER:
        if (start_edge || ovr_tc)
          state_d = ST_READY;
      default:
        state_d = ST_READY;
    endcase
  end

  assign chg = (state_d != state_q);

  // state, one-hot flags and clear pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_READY;
      bus.ready_o <= 1'b1;
      bus.play_o  <= 1'b0;
      bus.pause_o <= 1'b0;
      bus.over_o  <= 1'b0;
      bus.clear_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus.ready_o <= (state_d == ST_READY);
      bus.play_o  <= (state_d == ST_PLAY);
`ifdef GAME_FLOW_PAUSE_EN
      bus.pause_o <= (state_d == ST_PAUSE);
`else
      bus.pause_o <= 1'b0;
`endif
      bus.over_o  <= (state_d == ST_OVER);
      bus.clear_o <= (state_q == ST_OVER) &&
                     (state_d == ST_READY);
    end
  end

  assign bus.state_o = state_q;

  game_timer #(
    .LIMIT (START_CYCLES),
    .CNT_W (CNT_W)
  ) u_rdy_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (chg),
    .en    (state_q == ST_READY),
    .tc    (rdy_tc)
  );

  game_timer #(
    .LIMIT (OVER_HOLD_CYCLES),
    .CNT_W (CNT_W)
  ) u_ovr_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (chg),
    .en    ((state_q == ST_OVER) &&
            (OVER_HOLD_CYCLES != 0)),
    .tc    (ovr_tc)
  );

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed checks of two
// controllers (hold 20 and hold 0).
module tb_game_flow_ctrl;

  localparam logic [1:0] RD = 2'd0;
  localparam logic [1:0] PL = 2'd1;
  localparam logic [1:0] PS = 2'd2;
  localparam logic [1:0] OV = 2'd3;

  logic clk;
  logic rst_a_n;
  logic rst_b_n;
  int   vectors;
  int   miscompares;

  game_flow_if ia ();
  game_flow_if ib ();

  game_flow_ctrl #(
    .START_CYCLES     (10),
    .OVER_HOLD_CYCLES (20),
    .CNT_W            (30)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_a_n),
    .bus   (ia)
  );

  game_flow_ctrl #(
    .START_CYCLES     (10),
    .OVER_HOLD_CYCLES (0),
    .CNT_W            (30)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_b_n),
    .bus   (ib)
  );

  logic [6:0] obs_a;
  logic [6:0] obs_b;

  assign obs_a = {ia.ready_o, ia.play_o,
                  ia.pause_o, ia.over_o,
                  ia.state_o, ia.clear_o};
  assign obs_b = {ib.ready_o, ib.play_o,
                  ib.pause_o, ib.over_o,
                  ib.state_o, ib.clear_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] w(
    input logic [1:0] s,
    input logic       c
  );
    w = {s == RD, s == PL, s == PS, s == OV, s, c};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string      tag,
    input logic [6:0] obs,
    input logic [6:0] exp
  );
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b",
             tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_a_n     = 1'b0;
    rst_b_n     = 1'b0;
    ia.start_i  = 1'b0;
    ia.pause_i  = 1'b0;
    ia.over_i   = 1'b0;
    ib.start_i  = 1'b0;
    ib.pause_i  = 1'b0;
    ib.over_i   = 1'b0;
    step(3);
    chk("rst_a", obs_a, w(RD, 1'b0));
    chk("rst_b", obs_b, w(RD, 1'b0));

    // auto start at edge 10, no clear
    rst_a_n = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      step(1);
      chk("a_auto_ready", obs_a, w(RD, 1'b0));
    end
    step(1);
    chk("a_auto_play", obs_a, w(PL, 1'b0));

    // over_i and pause edge together
    ia.over_i  = 1'b1;
    ia.pause_i = 1'b1;
    step(1);
    chk("a_over_wins", obs_a, w(OV, 1'b0));
    ia.over_i  = 1'b0;
    ia.pause_i = 1'b0;
    step(19);
    chk("a_over_hold", obs_a, w(OV, 1'b0));
    step(1);
    chk("a_over_ret", obs_a, w(RD, 1'b1));
    step(1);
    chk("a_clr_once", obs_a, w(RD, 1'b0));

    // start edge at edge 3 -> PLAY at 4
    rst_a_n = 1'b0;
    step(2);
    rst_a_n = 1'b1;
    step(3);
    chk("a_pre_start", obs_a, w(RD, 1'b0));
    ia.start_i = 1'b1;
    step(1);
    chk("a_start", obs_a, w(PL, 1'b0));
    ia.start_i = 1'b0;

    // start held through reset release
    rst_a_n    = 1'b0;
    ia.start_i = 1'b1;
    step(2);
    chk("a_rst_abort", obs_a, w(RD, 1'b0));
    rst_a_n = 1'b1;
    step(9);
    chk("a_held_noedge", obs_a, w(RD, 1'b0));
    step(1);
    chk("a_held_auto", obs_a, w(PL, 1'b0));
    ia.start_i = 1'b0;

    // start edge coincides with auto start
    rst_a_n = 1'b0;
    step(2);
    rst_a_n = 1'b1;
    step(9);
    ia.start_i = 1'b1;
    step(1);
    chk("a_coin_play", obs_a, w(PL, 1'b0));
    ia.start_i = 1'b0;
    step(1);
    chk("a_coin_once", obs_a, w(PL, 1'b0));

    // pause handling
    ia.pause_i = 1'b1;
    step(1);
`ifdef GAME_FLOW_PAUSE_EN
    chk("a_pause_in", obs_a, w(PS, 1'b0));
    ia.pause_i = 1'b0;
    ia.over_i  = 1'b1;
    ia.start_i = 1'b1;
    step(5);
    chk("a_pause_hold", obs_a, w(PS, 1'b0));
    ia.over_i  = 1'b0;
    ia.start_i = 1'b0;
    ia.pause_i = 1'b1;
    step(1);
    chk("a_pause_out", obs_a, w(PL, 1'b0));
    ia.pause_i = 1'b0;
`else
    chk("a_pause_ign", obs_a, w(PL, 1'b0));
    ia.pause_i = 1'b0;
    step(1);
    ia.pause_i = 1'b1;
    step(1);
    chk("a_pause_ign2", obs_a, w(PL, 1'b0));
    ia.pause_i = 1'b0;
`endif

    // start edge leaves OVER early
    ia.over_i = 1'b1;
    step(1);
    chk("a_over2", obs_a, w(OV, 1'b0));
    ia.over_i = 1'b0;
    step(2);
    ia.start_i = 1'b1;
    step(1);
    chk("a_start_ovr", obs_a, w(RD, 1'b1));
    ia.start_i = 1'b0;
    step(1);
    chk("a_clr_once2", obs_a, w(RD, 1'b0));

    // hold 0: OVER waits for start
    rst_b_n = 1'b1;
    step(2);
    ib.start_i = 1'b1;
    step(1);
    chk("b_start", obs_b, w(PL, 1'b0));
    ib.start_i = 1'b0;
    ib.over_i  = 1'b1;
    step(1);
    chk("b_over", obs_b, w(OV, 1'b0));
    ib.over_i = 1'b0;
    step(1000);
    chk("b_over_hold", obs_b, w(OV, 1'b0));
    ib.start_i = 1'b1;
    step(1);
    chk("b_start_ovr", obs_b, w(RD, 1'b1));
    ib.start_i = 1'b0;
    step(1);
    chk("b_clr_once", obs_b, w(RD, 1'b0));
    step(8);
    chk("b_ready9", obs_b, w(RD, 1'b0));
    step(1);
    chk("b_auto_play", obs_b, w(PL, 1'b0));

    // async reset mid-PLAY, timing restarts
    #3;
    rst_b_n = 1'b0;
    #1;
    chk("b_async_rst", obs_b, w(RD, 1'b0));
    step(1);
    rst_b_n = 1'b1;
    step(9);
    chk("b_rst_ready", obs_b, w(RD, 1'b0));
    step(1);
    chk("b_rst_play", obs_b, w(PL, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
